gpio_in: RTL and testbench

- Input-direction counterpart of the LED GPIO block: samples NUM_PINS active-low push-button pins, synchronises and debounces them, and exposes them on the same peripheral register bus.
- Latches selected edges into write-1-to-clear pending bits and raises a level interrupt toward the core.
- Sits on the peripheral bus beside the output GPIO, with an identical write/read port shape.

---
 rtl/gpio_in_pkg.sv | 10 +
 rtl/gpio_in_debounce.sv | 45 ++++
 rtl/gpio_in.sv | 93 +++++++++
 tb/tb_gpio_in.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_in_pkg.sv
// Shared register map and bus constants for the push-button input GPIO block.
package gpio_in_pkg;
    localparam int              BUS_W            = 32;
    localparam logic [BUS_W-1:0] ZERO_WORD       = '0;
    localparam logic [3:0]      GPIO_IN_CTRL     = 4'h0;
    localparam logic [3:0]      GPIO_IN_DATA     = 4'h4;
    localparam logic [3:0]      GPIO_IN_PEND     = 4'h8;
    localparam int              GPIO_IN_GIE      = 8;
    localparam int              GPIO_IN_EDGE_LSB = 4;
endpackage

// File: rtl/gpio_in_debounce.sv
// Single-pin 2-flop synchroniser plus debounce counter; emits the accepted level
// and one-cycle press/release pulses that coincide with the stable update.
module gpio_in_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic stable,
    output logic press,
    output logic rls
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // Pulses are combinational so PEND latches on the same edge stable flips.
    assign accept = (sync2 != stable) && !(cnt < LAST);
    assign press  = accept & ~sync2;
    assign rls    = accept &  sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt < LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                stable <= sync2;
                cnt    <= '0;
            end
        end
    end
endmodule

// File: rtl/gpio_in.sv
// Debounced active-low button inputs with edge-latched W1C pending bits and a
// level interrupt, on the same register bus shape as the output GPIO.
module gpio_in
    import gpio_in_pkg::*;
#(
    parameter int NUM_PINS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_i,
    input  logic [BUS_W-1:0]    wr_addr_i,
    input  logic [BUS_W-1:0]    wr_data_i,
    input  logic [BUS_W-1:0]    rd_addr_i,
    output logic [BUS_W-1:0]    rd_data_o,
    input  logic [NUM_PINS-1:0] gpio_pins_i,
    output logic                irq_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [NUM_PINS-1:0] stable, press, rls, set_vec;
    logic [NUM_PINS-1:0] ie, ie_nxt, edge_sel, edge_nxt, pend, pend_nxt;
    logic                gie, gie_nxt;
    logic [BUS_W-1:0]    rd_nxt;
    logic                unused_bits;

    assign unused_bits = ^{wr_addr_i, rd_addr_i, wr_data_i};

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        gpio_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .pin   (gpio_pins_i[i]),
            .stable(stable[i]),
            .press (press[i]),
            .rls   (rls[i])
        );
    end

    assign set_vec = ie & ((edge_sel & rls) | (~edge_sel & press));

    always_comb begin
        ie_nxt   = ie;
        edge_nxt = edge_sel;
        gie_nxt  = gie;
        pend_nxt = pend;
        if (wr_en_i && wr_addr_i[3:0] == GPIO_IN_CTRL) begin
            ie_nxt   = wr_data_i[NUM_PINS-1:0];
            edge_nxt = wr_data_i[GPIO_IN_EDGE_LSB +: NUM_PINS];
            gie_nxt  = wr_data_i[GPIO_IN_GIE];
        end
        if (wr_en_i && wr_addr_i[3:0] == GPIO_IN_PEND)
            pend_nxt = pend & ~wr_data_i[NUM_PINS-1:0];
        // A new event always survives a simultaneous clear.
        pend_nxt = pend_nxt | set_vec;
    end

    // Reads see post-write CTRL/PEND so software never observes a stale value.
    always_comb begin
        rd_nxt = ZERO_WORD;
        case (rd_addr_i[3:0])
            GPIO_IN_CTRL: begin
                rd_nxt[NUM_PINS-1:0]                  = ie_nxt;
                rd_nxt[GPIO_IN_EDGE_LSB +: NUM_PINS]  = edge_nxt;
                rd_nxt[GPIO_IN_GIE]                   = gie_nxt;
            end
            GPIO_IN_DATA: rd_nxt[NUM_PINS-1:0] = ~stable;
            GPIO_IN_PEND: rd_nxt[NUM_PINS-1:0] = pend_nxt;
            default:      rd_nxt = ZERO_WORD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie        <= '0;
            edge_sel  <= '0;
            gie       <= 1'b0;
            pend      <= '0;
            rd_data_o <= ZERO_WORD;
            irq_o     <= 1'b0;
        end else begin
            ie        <= ie_nxt;
            edge_sel  <= edge_nxt;
            gie       <= gie_nxt;
            pend      <= pend_nxt;
            rd_data_o <= rd_nxt;
            irq_o     <= gie & |pend;
        end
    end
endmodule

// File: tb/tb_gpio_in.sv
// Directed tables and sequences for gpio_in, then randomized traffic against a
// window-based reference model of debounce, edge latching and the register map.
module tb_gpio_in;
    localparam int NP = 4;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [31:0]   wr_addr, wr_data, rd_addr, rd_data;
    logic [NP-1:0] pins;
    logic          irq;

    int errors = 0;
    int checks = 0;

    gpio_in #(.NUM_PINS(NP), .DEBOUNCE_CYCLES(DC)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .gpio_pins_i(pins),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] ra;
        logic [31:0] rd;
        logic        irq;
    } vec_t;

    vec_t rst_tbl[4];
    vec_t reg_tbl[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input string name, input vec_t v);
        wr_en   = v.wr;
        wr_addr = v.wa;
        wr_data = v.wd;
        rd_addr = v.ra;
        tick();
        wr_en = 1'b0;
        check({name, "_rd"}, rd_data, v.rd);
        check({name, "_irq"}, {31'b0, irq}, {31'b0, v.irq});
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Reference model: stable flips once the last DC synchronised samples all differ.
    logic [8:0]    m_ctrl;
    logic [NP-1:0] m_pend, m_stable;
    logic [NP-1:0] raw_q[$];
    logic [NP-1:0] win_q[$];
    logic [31:0]   m_rd;
    logic          m_irq;

    task automatic model_reset();
        m_ctrl   = '0;
        m_pend   = '0;
        m_stable = '1;
        raw_q.delete();
        win_q.delete();
        raw_q.push_back('1);
        raw_q.push_back('1);
    endtask

    task automatic model_step();
        logic [NP-1:0] sv, set, nstable, npend;
        logic [8:0]    nctrl;
        logic          all_diff, is_press;
        sv = raw_q.pop_front();
        raw_q.push_back(pins);
        win_q.push_back(sv);
        if (win_q.size() > DC) void'(win_q.pop_front());
        set     = '0;
        nstable = m_stable;
        for (int i = 0; i < NP; i++) begin
            if (win_q.size() == DC) begin
                all_diff = 1'b1;
                foreach (win_q[k]) if (win_q[k][i] == m_stable[i]) all_diff = 1'b0;
                if (all_diff) begin
                    nstable[i] = ~m_stable[i];
                    is_press   = m_stable[i];
                    if (m_ctrl[i] && (m_ctrl[4+i] ? !is_press : is_press)) set[i] = 1'b1;
                end
            end
        end
        nctrl = m_ctrl;
        npend = m_pend;
        if (wr_en && wr_addr[3:0] == 4'h0) nctrl = wr_data[8:0];
        if (wr_en && wr_addr[3:0] == 4'h8) npend = m_pend & ~wr_data[NP-1:0];
        npend = npend | set;
        m_irq = m_ctrl[8] & (m_pend != 0);
        case (rd_addr[3:0])
            4'h0:    m_rd = {23'b0, nctrl};
            4'h4:    m_rd = {28'b0, ~m_stable};
            4'h8:    m_rd = {28'b0, npend};
            default: m_rd = 32'h0;
        endcase
        m_ctrl   = nctrl;
        m_pend   = npend;
        m_stable = nstable;
    endtask

    int unsigned hold[NP];

    initial begin
        rst_tbl[0] = '{1'b0, 32'h0, 32'h0,         32'h0, 32'h0,   1'b0};
        rst_tbl[1] = '{1'b0, 32'h0, 32'h0,         32'h4, 32'h0,   1'b0};
        rst_tbl[2] = '{1'b0, 32'h0, 32'h0,         32'h8, 32'h0,   1'b0};
        rst_tbl[3] = '{1'b1, 32'h0, 32'h1FF,       32'hC, 32'h0,   1'b0};
        reg_tbl[0] = '{1'b1, 32'h0, 32'h103,       32'h0, 32'h103, 1'b0};
        reg_tbl[1] = '{1'b0, 32'h0, 32'h0,         32'h8, 32'h3,   1'b1};
        reg_tbl[2] = '{1'b0, 32'h0, 32'h0,         32'hC, 32'h0,   1'b1};
        reg_tbl[3] = '{1'b1, 32'hC, 32'hFFFF_FFFF, 32'h0, 32'h103, 1'b1};
        reg_tbl[4] = '{1'b1, 32'h4, 32'hF,         32'h4, 32'h2,   1'b1};
        reg_tbl[5] = '{1'b1, 32'h8, 32'h1,         32'h8, 32'h2,   1'b1};
        reg_tbl[6] = '{1'b1, 32'h8, 32'h2,         32'h8, 32'h0,   1'b1};
        reg_tbl[7] = '{1'b0, 32'h0, 32'h0,         32'hC, 32'h0,   1'b0};

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        pins = '1;
        pins[0] = 1'b0;
        #1;
        // 1: reset, pin0 held low through it
        foreach (rst_tbl[i]) apply_vec("reset", rst_tbl[i]);
        rst = 1'b0;
        rd_addr = 32'h4;
        repeat (6) tick();
        check("rst_data_pre", rd_data, 32'h0);
        tick();
        check("rst_data_held", rd_data, 32'h1);
        rd_addr = 32'h8;
        tick();
        check("rst_no_pend", rd_data, 32'h0);
        pins[0] = 1'b1;
        repeat (8) tick();

        // 2: press with irq enabled
        apply_vec("ctrl_101", '{1'b1, 32'h0, 32'h101, 32'h0, 32'h101, 1'b0});
        pins[0] = 1'b0;
        rd_addr = 32'h8;
        repeat (5) tick();
        check("press_pend_early", rd_data, 32'h0);
        tick();
        check("press_pend", rd_data, 32'h1);
        check("press_irq_early", {31'b0, irq}, 32'h0);
        rd_addr = 32'h4;
        tick();
        check("press_irq", {31'b0, irq}, 32'h1);
        check("press_data", rd_data, 32'h1);
        pins[0] = 1'b1;
        write(32'h8, 32'h1);
        rd_addr = 32'h8;
        repeat (8) tick();
        check("release_ignored_pend", rd_data, 32'h0);
        check("release_ignored_irq", {31'b0, irq}, 32'h0);

        // 3: two 3-cycle glitches one cycle apart
        pins[1] = 1'b0; repeat (3) tick();
        pins[1] = 1'b1; tick();
        pins[1] = 1'b0; repeat (3) tick();
        pins[1] = 1'b1;
        rd_addr = 32'h4;
        repeat (8) tick();
        check("glitch_data", rd_data, 32'h0);
        rd_addr = 32'h8;
        tick();
        check("glitch_pend", rd_data, 32'h0);

        // 4: release-edge select on pin2
        apply_vec("ctrl_1f4", '{1'b1, 32'h0, 32'h1F4, 32'h0, 32'h1F4, 1'b0});
        pins[2] = 1'b0;
        rd_addr = 32'h8;
        repeat (10) tick();
        check("rel_press_pend", rd_data, 32'h0);
        rd_addr = 32'h4;
        tick();
        check("rel_press_data", rd_data, 32'h4);
        pins[2] = 1'b1;
        rd_addr = 32'h8;
        repeat (5) tick();
        check("rel_pend_early", rd_data, 32'h0);
        tick();
        check("rel_pend", rd_data, 32'h4);
        tick();
        check("rel_irq", {31'b0, irq}, 32'h1);
        write(32'h8, 32'h4);
        check("w1c_rd", rd_data, 32'h0);
        check("w1c_irq_lag", {31'b0, irq}, 32'h1);
        tick();
        check("w1c_irq_off", {31'b0, irq}, 32'h0);

        // 5: clear racing with a new press event
        write(32'h0, 32'h101);
        pins[0] = 1'b0;
        rd_addr = 32'h8;
        repeat (5) tick();
        write(32'h8, 32'h1);
        check("race_rd", rd_data, 32'h1);
        tick();
        check("race_pend", rd_data, 32'h1);
        check("race_irq", {31'b0, irq}, 32'h1);

        // 6: gie masking, unmapped offset, read-only DATA
        write(32'h0, 32'h003);
        tick();
        check("gie_off_irq", {31'b0, irq}, 32'h0);
        pins[0] = 1'b1;
        pins[1] = 1'b0;
        rd_addr = 32'h8;
        repeat (10) tick();
        check("masked_pend", rd_data, 32'h3);
        check("masked_irq", {31'b0, irq}, 32'h0);
        foreach (reg_tbl[i]) apply_vec("regmap", reg_tbl[i]);

        // randomized traffic against the model
        rst = 1'b1;
        tick();
        model_reset();
        rst = 1'b0;
        foreach (hold[i]) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (hold[i] == 0) begin
                    pins[i] = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 9);
                end
                hold[i]--;
            end
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_addr = $urandom();
            wr_addr[3:0] = 4'($urandom_range(0, 3) * 4);
            wr_data = $urandom();
            rd_addr = $urandom();
            rd_addr[3:0] = 4'($urandom_range(0, 3) * 4);
            model_step();
            tick();
            check("rand_rd", rd_data, m_rd);
            check("rand_irq", {31'b0, irq}, {31'b0, m_irq});
        end
        wr_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
